// File: rtl/bias_stream_gen_pkg.sv
// Shared types and helpers for the bias stream generator.
package bias_stream_gen_pkg;

  // Run control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Depth of the output skid buffer; two entries cover the ROM's one-cycle latency.
  localparam int FIFO_DEPTH = 2;

  // Bits needed for a counter running 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bias_stream_gen_rom.sv
// Synchronous-read bias ROM, one word per address, one cycle of read latency.
// Contents are elaborated from init_image (word 0 in the LSBs); mem_file names
// the image the contents were generated from.
module bias_stream_gen_rom #(
  parameter int    mem_size   = 16,
  parameter int    data_width = 16,
  parameter int    addr_width = 4,
  parameter string mem_file   = "./bias.mem",
  parameter logic [mem_size*data_width-1:0] init_image = '0
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [addr_width-1:0] addr,
  output logic [data_width-1:0] q
);

  logic [data_width-1:0] words [mem_size];

  for (genvar gi = 0; gi < mem_size; gi++) begin : g_word
    assign words[gi] = init_image[gi*data_width +: data_width];
  end

  // An empty image name means the contents come purely from init_image.
  if (mem_file == "") begin : g_inline_image
  end

  // Registered read; the output holds when no read is enabled.
  always_ff @(posedge clk) begin
    if (en) begin
      q <= words[addr];
    end
  end

endmodule

// File: rtl/bias_stream_gen.sv
// Streams a layer's bias vector from ROM onto an ap_fifo output, with lane
// packing, per-word repeat, frame looping and ap_start/ap_done/ap_idle control.
module bias_stream_gen
  import bias_stream_gen_pkg::*;
#(
  parameter int    N_CH        = 16,
  parameter int    LANES       = 1,
  parameter int    COEFF_WIDTH = 16,
  parameter int    REPEAT      = 1,
  parameter int    FRAMES      = 1,
  parameter string MEM_FILE    = "./bias.mem",
  parameter logic [N_CH*COEFF_WIDTH-1:0] INIT_IMAGE = '0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ap_start,
  output logic                         ap_done,
  output logic                         ap_idle,
  output logic [LANES*COEFF_WIDTH-1:0] output_V_din,
  input  logic                         output_V_full_n,
  output logic                         output_V_write
);

  localparam int WORDS  = N_CH / LANES;
  localparam int ADDR_W = width_of(WORDS);
  localparam int REP_W  = width_of(REPEAT);
  localparam int FRM_W  = width_of(FRAMES);
  localparam int DATA_W = LANES * COEFF_WIDTH;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WORDS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'((FRAMES == 0) ? 0 : FRAMES - 1);

  state_t state_reg, state_next;

  logic [REP_W-1:0]  rep_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [FRM_W-1:0]  frame_reg;
  logic              inflight_reg;
  logic              done_reg, done_next;

  logic [DATA_W-1:0] fifo_mem_reg [FIFO_DEPTH];
  logic              rd_ptr_reg, wr_ptr_reg;
  logic [1:0]        count_reg, count_next;
  logic [1:0]        occupancy;

  logic              rd_en, push, pop, head_valid;
  logic              rep_wrap, addr_wrap, last_read;
  logic [DATA_W-1:0] rom_q;

  bias_stream_gen_rom #(
    .mem_size   (WORDS),
    .data_width (DATA_W),
    .addr_width (ADDR_W),
    .mem_file   (MEM_FILE),
    .init_image (INIT_IMAGE)
  ) u_rom (
    .clk  (ap_clk),
    .en   (rd_en),
    .addr (addr_reg),
    .q    (rom_q)
  );

  // ROM data arrives one cycle after the read; it is pushed as soon as it is valid.
  assign push       = inflight_reg;
  assign head_valid = (count_reg != 2'd0);
  assign pop        = head_valid & output_V_full_n;

  assign output_V_write = pop;
  assign output_V_din   = head_valid ? fifo_mem_reg[rd_ptr_reg] : '0;
  assign ap_done        = done_reg;
  assign ap_idle        = (state_reg == ST_IDLE);

  assign rep_wrap  = (rep_reg == REP_LAST);
  assign addr_wrap = rep_wrap && (addr_reg == ADDR_LAST);
  assign last_read = addr_wrap && (frame_reg == FRM_LAST) && (FRAMES != 0);

  // Buffer occupancy after this edge, and words already committed to it.
  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
    occupancy = count_reg + {1'b0, inflight_reg};
  end

  // Next-state, read issue and done pulse. A read may be issued while the
  // buffer is committed full if a word leaves this same cycle, which keeps
  // one word per cycle flowing.
  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    done_next  = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (ap_start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        rd_en = (occupancy < 2'd2) || pop;
        if (rd_en && last_read) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_reg && (count_next == 2'd0)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and done pulse registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  // Repeat, address and frame counters step once per issued read.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rep_reg      <= '0;
      addr_reg     <= '0;
      frame_reg    <= '0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      if (rd_en) begin
        rep_reg <= rep_wrap ? '0 : rep_reg + 1'b1;
        if (rep_wrap) begin
          addr_reg <= (addr_reg == ADDR_LAST) ? '0 : addr_reg + 1'b1;
        end
        if (addr_wrap) begin
          frame_reg <= (frame_reg == FRM_LAST) ? '0 : frame_reg + 1'b1;
        end
      end
    end
  end

  // Skid buffer pointers and occupancy.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  // Skid buffer storage; contents are don't-care while the entry is empty.
  always_ff @(posedge ap_clk) begin
    if (push) begin
      fifo_mem_reg[wr_ptr_reg] <= rom_q;
    end
  end

endmodule

// File: tb/tb_bias_stream_gen.sv
// Scoreboard bench for bias_stream_gen: three configurations (repeat/frames,
// packed lanes, continuous) driven with randomized back-pressure.
module tb_bias_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference bias vector shared by configs A and C.
  int rom_ref [4] = '{10, 20, 30, 40};

  // Config A: N_CH=4, LANES=1, REPEAT=3, FRAMES=2.
  logic        rst_a, start_a, full_a, done_a, idle_a, write_a;
  logic [15:0] din_a;
  // Config B: N_CH=4, LANES=2, REPEAT=1, FRAMES=1.
  logic        rst_b, start_b, full_b, done_b, idle_b, write_b;
  logic [31:0] din_b;
  // Config C: N_CH=4, LANES=1, REPEAT=3, FRAMES=0.
  logic        rst_c, start_c, full_c, done_c, idle_c, write_c;
  logic [15:0] din_c;

  bias_stream_gen #(.N_CH(4), .LANES(1), .COEFF_WIDTH(16), .REPEAT(3), .FRAMES(2),
    .MEM_FILE(""), .INIT_IMAGE({16'd40, 16'd30, 16'd20, 16'd10})) dut_a (
    .ap_clk(clk), .ap_rst(rst_a), .ap_start(start_a), .ap_done(done_a), .ap_idle(idle_a),
    .output_V_din(din_a), .output_V_full_n(full_a), .output_V_write(write_a));

  bias_stream_gen #(.N_CH(4), .LANES(2), .COEFF_WIDTH(16), .REPEAT(1), .FRAMES(1),
    .MEM_FILE(""), .INIT_IMAGE({16'h0028, 16'h001E, 16'h0014, 16'h000A})) dut_b (
    .ap_clk(clk), .ap_rst(rst_b), .ap_start(start_b), .ap_done(done_b), .ap_idle(idle_b),
    .output_V_din(din_b), .output_V_full_n(full_b), .output_V_write(write_b));

  bias_stream_gen #(.N_CH(4), .LANES(1), .COEFF_WIDTH(16), .REPEAT(3), .FRAMES(0),
    .MEM_FILE(""), .INIT_IMAGE({16'd40, 16'd30, 16'd20, 16'd10})) dut_c (
    .ap_clk(clk), .ap_rst(rst_c), .ap_start(start_c), .ap_done(done_c), .ap_idle(idle_c),
    .output_V_din(din_c), .output_V_full_n(full_c), .output_V_write(write_c));

  logic [15:0] exp_a [$];
  logic [31:0] exp_b [$];
  logic [15:0] exp_c [$];

  int wr_cnt_a, first_wr_a, last_wr_a, miss_a, done_cnt_a, done_cyc_a;
  int wr_cnt_b, done_cnt_b;
  int wr_cnt_c, done_cnt_c;

  function automatic void check(input string name, input longint actual, input longint expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: pops the scoreboard on every write, tracks timing and gaps.
  always @(negedge clk) begin : mon_a
    logic [15:0] e;
    if (write_a) begin
      tests_run++;
      if (exp_a.size() == 0) begin
        tests_failed++;
        $display("FAIL a_extra_write: got din %0d, required no write", din_a);
      end else begin
        e = exp_a.pop_front();
        if (din_a !== e || !full_a) begin
          tests_failed++;
          $display("FAIL a_data: got %0d (full_n %0b), required %0d with full_n 1", din_a, full_a, e);
        end
      end
      if (wr_cnt_a == 0) first_wr_a = cyc;
      last_wr_a = cyc;
      wr_cnt_a++;
    end else if (full_a && exp_a.size() > 0 && wr_cnt_a > 0) begin
      miss_a++;
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
  end

  // Monitor B: packed-lane words.
  always @(negedge clk) begin : mon_b
    logic [31:0] e;
    if (write_b) begin
      tests_run++;
      if (exp_b.size() == 0) begin
        tests_failed++;
        $display("FAIL b_extra_write: got din %0h, required no write", din_b);
      end else begin
        e = exp_b.pop_front();
        if (din_b !== e) begin
          tests_failed++;
          $display("FAIL b_data: got %0h, required %0h", din_b, e);
        end
      end
      wr_cnt_b++;
    end
    if (done_b) done_cnt_b++;
  end

  // Monitor C: continuous stream, done must never pulse.
  always @(negedge clk) begin : mon_c
    logic [15:0] e;
    if (write_c) begin
      if (exp_c.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL c_extra_write: got din %0d, required no write", din_c);
      end else begin
        e = exp_c.pop_front();
        if (din_c !== e) begin
          tests_run++;
          tests_failed++;
          $display("FAIL c_data: write %0d got %0d, required %0d", wr_cnt_c, din_c, e);
        end
      end
      wr_cnt_c++;
    end
    if (done_c) done_cnt_c++;
  end

  // Config A run. mode: 0 full_n=1, 1 toggled, 2 random, 3 long stall, 4 start held over two runs.
  task automatic run_a(input int mode, input string name);
    int runs, budget, start_cyc, n_exp;
    bit stalled;
    logic [15:0] cap;
    runs = (mode == 4) ? 2 : 1;
    for (int r = 0; r < runs; r++)
      for (int f = 0; f < 2; f++)
        for (int a = 0; a < 4; a++)
          for (int k = 0; k < 3; k++)
            exp_a.push_back(16'(rom_ref[a]));
    n_exp = exp_a.size();
    wr_cnt_a = 0; miss_a = 0; done_cnt_a = 0; first_wr_a = -1; last_wr_a = -1; done_cyc_a = -1;
    stalled = 0;
    full_a = 1'b1;
    start_a = 1'b1;
    start_cyc = cyc;
    tick();
    if (mode != 4) start_a = 1'b0;
    budget = 0;
    while (done_cnt_a < runs && budget < 600) begin
      case (mode)
        1: full_a = ~full_a;
        2: full_a = ($urandom_range(0, 3) != 0);
        3: if (!stalled && wr_cnt_a >= 5) begin
             stalled = 1;
             full_a = 1'b0;
             #1;
             cap = din_a;
             check({name, "_stall_head"}, din_a, exp_a[0]);
             for (int s = 0; s < 20; s++) begin
               if (s > 0) begin tick(); #1; end
               check({name, "_stall_hold"}, {write_a, din_a}, {1'b0, cap});
             end
             tick();
             full_a = 1'b1;
           end
        default: ;
      endcase
      if (mode == 4 && done_cnt_a >= 1) start_a = 1'b0;
      tick();
      budget++;
    end
    start_a = 1'b0;
    full_a = 1'b1;
    check({name, "_finished"}, done_cnt_a >= runs, 1);
    check({name, "_writes"}, wr_cnt_a, n_exp);
    check({name, "_queue_empty"}, exp_a.size(), 0);
    check({name, "_done_count"}, done_cnt_a, runs);
    if (mode != 4) check({name, "_done_after_last"}, done_cyc_a, last_wr_a + 1);
    if (mode == 0 || mode == 1 || mode == 3) check({name, "_no_gaps"}, miss_a, 0);
    if (mode == 0) begin
      check({name, "_latency"}, first_wr_a, start_cyc + 3);
      check({name, "_back_to_back"}, last_wr_a - first_wr_a, n_exp - 1);
    end
    if (mode == 3) check({name, "_stall_seen"}, stalled, 1);
    check({name, "_idle_after"}, {idle_a, done_a, write_a}, 3'b100);
    $display("[TB] run %s: %0d writes, first cycle %0d, last cycle %0d, done cycle %0d",
             name, wr_cnt_a, first_wr_a, last_wr_a, done_cyc_a);
    tick();
  endtask

  // Config A: reset after 7 writes truncates the stream.
  task automatic reset_mid_a();
    int budget;
    for (int f = 0; f < 2; f++)
      for (int a = 0; a < 4; a++)
        for (int k = 0; k < 3; k++)
          exp_a.push_back(16'(rom_ref[a]));
    wr_cnt_a = 0; miss_a = 0; done_cnt_a = 0;
    full_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    budget = 0;
    while (wr_cnt_a < 7 && budget < 100) begin
      tick();
      budget++;
    end
    full_a = 1'b0;
    rst_a = 1'b1;
    tick();
    full_a = 1'b1;
    #1;
    check("rst_mid_writes", wr_cnt_a, 7);
    check("rst_mid_outputs", {write_a, idle_a, done_a, din_a}, {1'b0, 1'b1, 1'b0, 16'd0});
    tick();
    rst_a = 1'b0;
    exp_a.delete();
    $display("[TB] run reset_mid: stream truncated after %0d writes", wr_cnt_a);
    tick();
    run_a(0, "after_reset");
  endtask

  // Config B: two packed words per run.
  task automatic run_b();
    int budget;
    exp_b.push_back(32'h0014_000A);
    exp_b.push_back(32'h0028_001E);
    wr_cnt_b = 0; done_cnt_b = 0;
    full_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    budget = 0;
    while (done_cnt_b < 1 && budget < 50) begin
      full_b = ($urandom_range(0, 1) != 0);
      tick();
      budget++;
    end
    full_b = 1'b1;
    tick();
    check("lanes_writes", wr_cnt_b, 2);
    check("lanes_queue_empty", exp_b.size(), 0);
    check("lanes_done", done_cnt_b, 1);
    check("lanes_idle", idle_b, 1);
    $display("[TB] run lanes: %0d writes, %0d done pulses", wr_cnt_b, done_cnt_b);
  endtask

  // Config C: 1000 writes of the cyclic sequence, then stopped by reset.
  task automatic run_c();
    int budget;
    for (int i = 0; i < 1000; i++) exp_c.push_back(16'(rom_ref[(i / 3) % 4]));
    wr_cnt_c = 0; done_cnt_c = 0;
    full_c = 1'b1;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    budget = 0;
    while (wr_cnt_c < 1000 && budget < 1200) begin
      tick();
      budget++;
    end
    full_c = 1'b0;
    check("cont_writes", wr_cnt_c, 1000);
    check("cont_queue_empty", exp_c.size(), 0);
    check("cont_no_done", done_cnt_c, 0);
    check("cont_still_running", idle_c, 0);
    rst_c = 1'b1;
    tick();
    tick();
    rst_c = 1'b0;
    check("cont_idle_after_reset", {idle_c, write_c}, 2'b10);
    $display("[TB] run continuous: %0d writes in %0d cycles", wr_cnt_c, budget);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    full_a = 1'b1; full_b = 1'b1; full_c = 1'b1;
    wr_cnt_a = 0; wr_cnt_b = 0; wr_cnt_c = 0;
    miss_a = 0; done_cnt_a = 0; done_cnt_b = 0; done_cnt_c = 0;
    first_wr_a = -1; last_wr_a = -1; done_cyc_a = -1;
    repeat (3) tick();
    check("reset_a", {write_a, done_a, idle_a, din_a}, {1'b0, 1'b0, 1'b1, 16'd0});
    check("reset_b", {write_b, done_b, idle_b, din_b}, {1'b0, 1'b0, 1'b1, 32'd0});
    check("reset_c", {write_c, done_c, idle_c, din_c}, {1'b0, 1'b0, 1'b1, 16'd0});
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
    run_a(0, "basic");
    run_a(1, "toggle");
    run_a(3, "long_stall");
    run_a(2, "random0");
    run_a(2, "random1");
    run_a(4, "start_held");
    reset_mid_a();
    run_b();
    run_c();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
